// File: rtl/input_conditioner_if.sv
// Pin-side bundle for the input conditioner: raw pin levels in, conditioned levels and pulses out.
// The master drives raw_in; the slave (the conditioner) drives everything else.
interface input_conditioner_if #(
    parameter int N_IN = 5
);
  logic [N_IN-1:0] raw_in;
  logic [N_IN-1:0] clean;
  logic [N_IN-1:0] rise;
  logic [N_IN-1:0] fall;
  logic [N_IN-1:0] toggle;

  modport master (output raw_in, input clean, rise, fall, toggle);
  modport slave  (input raw_in, output clean, rise, fall, toggle);
endinterface

// File: rtl/input_conditioner.sv
// Per-channel synchroniser + debounce FSM producing clean level, rise/fall pulses and a push toggle.
// Latency SYNC_STAGES+DB_CYCLES+1 edges from a stable raw level; no backpressure, outputs registered.
module input_conditioner #(
    parameter int N_IN        = 5,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 250000
) (
    input logic              clk,
    input logic              rst,
    input_conditioner_if.slave io
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LO,
    WAIT_HI,
    ST_HI,
    WAIT_LO
  } state_t;

  if (DB_CYCLES < 1 || SYNC_STAGES < 2) begin : g_param_check
    $error("input_conditioner: DB_CYCLES must be >= 1 and SYNC_STAGES >= 2");
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sff;
    logic                   sync;
    state_t                 st;
    logic [CW-1:0]          cnt;
    logic                   c_clean;
    logic                   c_rise;
    logic                   c_fall;
    logic                   c_tog;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) sff <= '0;
      else     sff <= {sff[SYNC_STAGES-2:0], io.raw_in[i]};
    end

    assign sync = sff[SYNC_STAGES-1];

    // Pulses default low so each lasts exactly the cycle in which clean changes.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st      <= ST_LO;
        cnt     <= '0;
        c_clean <= 1'b0;
        c_rise  <= 1'b0;
        c_fall  <= 1'b0;
        c_tog   <= 1'b0;
      end else begin
        c_rise <= 1'b0;
        c_fall <= 1'b0;
        case (st)
          ST_LO: begin
            c_clean <= 1'b0;
            if (sync) begin
              st  <= WAIT_HI;
              cnt <= '0;
            end
          end
          WAIT_HI: begin
            if (!sync) begin
              st <= ST_LO;
            end else if (cnt == CNT_LAST) begin
              st      <= ST_HI;
              c_clean <= 1'b1;
              c_rise  <= 1'b1;
              c_tog   <= ~c_tog;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_HI: begin
            c_clean <= 1'b1;
            if (!sync) begin
              st  <= WAIT_LO;
              cnt <= '0;
            end
          end
          WAIT_LO: begin
            if (sync) begin
              st <= ST_HI;
            end else if (cnt == CNT_LAST) begin
              st      <= ST_LO;
              c_clean <= 1'b0;
              c_fall  <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: st <= ST_LO;
        endcase
      end
    end

    assign io.clean[i]  = c_clean;
    assign io.rise[i]   = c_rise;
    assign io.fall[i]   = c_fall;
    assign io.toggle[i] = c_tog;
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DB_CYCLES=4, SYNC_STAGES=2 (7-edge latency).
// Stimulus queues expected pulse events; a negedge monitor matches them against DUT pulses.
module tb_input_conditioner;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   passes;

  input_conditioner_if #(.N_IN(5)) cif ();

  input_conditioner #(
      .N_IN       (5),
      .SYNC_STAGES(2),
      .DB_CYCLES  (4)
  ) dut (
      .clk(clk),
      .rst(rst),
      .io (cif.slave)
  );

  typedef struct {
    int         cyc;
    logic [4:0] clean;
    logic [4:0] rise;
    logic [4:0] fall;
    logic [4:0] toggle;
  } exp_t;

  exp_t sb[$];

  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Expected event 7 edges after the current (negedge) drive point.
  task automatic expect_evt(input logic [4:0] cl, input logic [4:0] ri,
                            input logic [4:0] fa, input logic [4:0] tg);
    exp_t e;
    e.cyc    = cyc + 7;
    e.clean  = cl;
    e.rise   = ri;
    e.fall   = fa;
    e.toggle = tg;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {12'h0, cif.clean, cif.rise, cif.fall, cif.toggle}, 32'h0);
  endtask

  // Monitor: every pulse on the outputs must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        $display("FAIL missing_evt: no pulse seen, expected at cycle %0d (now %0d)", sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if ((cif.rise | cif.fall) != 5'b0) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_pulse: rise=%b fall=%b at cycle %0d, none expected",
                   cif.rise, cif.fall, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("evt_cycle",  cyc,        e.cyc);
          chk("evt_clean",  cif.clean,  e.clean);
          chk("evt_rise",   cif.rise,   e.rise);
          chk("evt_fall",   cif.fall,   e.fall);
          chk("evt_toggle", cif.toggle, e.toggle);
        end
      end
    end
  end

  initial begin
    cyc        = 0;
    checks     = 0;
    passes     = 0;
    rst        = 1'b1;
    cif.raw_in = 5'b11111;

    // Test 1: held-high inputs through reset, then release.
    tick(1);
    for (int k = 0; k < 4; k++) begin
      chk_all_zero("t1_in_reset");
      tick(1);
    end
    rst = 1'b0;
    expect_evt(5'b11111, 5'b11111, 5'b00000, 5'b11111);
    tick(10);

    // Return to a clean all-low state.
    cif.raw_in = 5'b00000;
    rst = 1'b1;
    #1 chk_all_zero("rst_clears");
    tick(1);
    rst = 1'b0;
    tick(4);

    // Test 2: single press on channel 0.
    cif.raw_in = 5'b00001;
    expect_evt(5'b00001, 5'b00001, 5'b00000, 5'b00001);
    tick(8);
    chk("t2_rise_drop", cif.rise[0], 1'b0);
    chk("t2_clean_held", cif.clean[0], 1'b1);
    tick(3);

    // Test 3: bouncing channel 1.
    cif.raw_in = 5'b00011; tick(3);
    cif.raw_in = 5'b00001; tick(1);
    cif.raw_in = 5'b00011; tick(2);
    cif.raw_in = 5'b00001; tick(1);
    cif.raw_in = 5'b00011;
    expect_evt(5'b00011, 5'b00010, 5'b00000, 5'b00011);
    tick(10);

    // Test 4: release channel 0, then another press/release.
    cif.raw_in = 5'b00010;
    expect_evt(5'b00010, 5'b00000, 5'b00001, 5'b00011);
    tick(10);
    cif.raw_in = 5'b00011;
    expect_evt(5'b00011, 5'b00001, 5'b00000, 5'b00010);
    tick(10);
    cif.raw_in = 5'b00010;
    expect_evt(5'b00010, 5'b00000, 5'b00001, 5'b00010);
    tick(10);

    // Test 5: channels 2 and 4 together.
    cif.raw_in = 5'b10110;
    expect_evt(5'b10110, 5'b10100, 5'b00000, 5'b10110);
    tick(10);

    // Test 6: channel 3 rises, reset lands when its count is 2.
    cif.raw_in = 5'b11110;
    tick(5);
    rst = 1'b1;
    #1 chk_all_zero("t6_rst_drop");
    tick(1);
    chk_all_zero("t6_rst_hold");
    rst = 1'b0;
    expect_evt(5'b11110, 5'b11110, 5'b00000, 5'b11110);
    tick(12);

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
